// File: rtl/stream_to_memory.sv
// stream_to_memory: deserializer that collects a word stream (rtr/rts/eow
// handshake) into a MEMORY_DEPTH-entry buffer and presents the complete frame
// in parallel, zero-padding entries beyond the number of words written.
module stream_to_memory #(
    parameter int DATA_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 20
) (
    input  logic                                clk,
    input  logic                                rst,
    // slave side (word stream in)
    output logic                                rtr_o,
    input  logic                                rts_i,
    input  logic                                eow_i,
    input  logic [DATA_WIDTH-1:0]               data_i,
    // master side (parallel frame out)
    input  logic                                rtr_i,
    output logic                                rts_o,
    output logic                                eow_o,
    output logic [$clog2(MEMORY_DEPTH+1)-1:0]   count_o,
    output logic [DATA_WIDTH-1:0]               data_o [MEMORY_DEPTH]
);

    localparam int CW  = $clog2(MEMORY_DEPTH + 1);
    localparam int WCW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_FILL,
        ST_FULL
    } state_t;

    state_t                 state_q, state_d;
    logic                   init_q, init_d;
    logic [WCW-1:0]         wc_q, wc_d;
    logic [DATA_WIDTH-1:0]  mem_q [MEMORY_DEPTH];
    logic [DATA_WIDTH-1:0]  mem_d [MEMORY_DEPTH];
    logic [CW-1:0]          count_q, count_d;
    logic                   eow_q, eow_d;
    logic                   rtr_q, rtr_d;
    logic                   rts_q, rts_d;
    logic                   accept;

    // A word is taken only while the registered ready is up (FILL only).
    assign accept = rts_i & rtr_q;

    // Next-state, buffer write and frame-latch logic.
    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        wc_d    = wc_q;
        mem_d   = mem_q;
        count_d = count_q;
        eow_d   = eow_q;

        unique case (state_q)
            ST_INIT: begin
                // INIT spends one full cycle after reset release, so ready
                // rises on the second edge.
                if (init_q) begin
                    state_d = ST_FILL;
                end else begin
                    init_d = 1'b1;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    mem_d[wc_q] = data_i;
                    if (eow_i || (wc_q == WCW'(MEMORY_DEPTH - 1))) begin
                        state_d = ST_FULL;
                        count_d = CW'(wc_q) + CW'(1);
                        eow_d   = eow_i;
                        wc_d    = '0;
                    end else begin
                        wc_d = wc_q + WCW'(1);
                    end
                end
            end
            ST_FULL: begin
                if (rtr_i) begin
                    state_d = ST_FILL;
                    count_d = '0;
                    eow_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Handshake outputs are registered from the next state, so they track
        // the state with no combinational path from rtr_i.
        rtr_d = (state_d == ST_FILL);
        rts_d = (state_d == ST_FULL);
    end

    // State, buffer and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            init_q  <= 1'b0;
            wc_q    <= '0;
            count_q <= '0;
            eow_q   <= 1'b0;
            rtr_q   <= 1'b0;
            rts_q   <= 1'b0;
            for (int unsigned i = 0; i < MEMORY_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            wc_q    <= wc_d;
            count_q <= count_d;
            eow_q   <= eow_d;
            rtr_q   <= rtr_d;
            rts_q   <= rts_d;
            for (int unsigned i = 0; i < MEMORY_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Present only entries written in this frame; the tail reads as zero so
    // data left over from an earlier, longer frame never shows through.
    always_comb begin
        for (int unsigned k = 0; k < MEMORY_DEPTH; k++) begin
            data_o[k] = (CW'(k) < count_q) ? mem_q[k] : '0;
        end
    end

    assign rtr_o   = rtr_q;
    assign rts_o   = rts_q;
    assign eow_o   = eow_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_stream_to_memory.sv
// Self-checking bench for stream_to_memory: directed and randomized word
// streams checked against a frame-level reference model.
module tb_stream_to_memory;

    localparam int DW = 16;
    localparam int MD = 20;
    localparam int CW = $clog2(MD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          rtr_o;
    logic          rts_i;
    logic          eow_i;
    logic [DW-1:0] data_i;
    logic          rtr_i;
    logic          rts_o;
    logic          eow_o;
    logic [CW-1:0] count_o;
    logic [DW-1:0] data_o [MD];

    always #5 clk = ~clk;

    stream_to_memory #(
        .DATA_WIDTH   (DW),
        .MEMORY_DEPTH (MD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rtr_o   (rtr_o),
        .rts_i   (rts_i),
        .eow_i   (eow_i),
        .data_i  (data_i),
        .rtr_i   (rtr_i),
        .rts_o   (rts_o),
        .eow_o   (eow_o),
        .count_o (count_o),
        .data_o  (data_o)
    );

    typedef struct {
        logic [MD-1:0][DW-1:0] w;
        int                    len;
        bit                    eow;
    } frame_t;

    frame_t        expq [$];
    logic [DW-1:0] src_w [$];
    bit            src_e [$];

    int n_pass   = 0;
    int n_fail   = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rtr"}, 32'(rtr_o), 0);
        chk({tag, "_rts"}, 32'(rts_o), 0);
        chk({tag, "_eow"}, 32'(eow_o), 0);
        chk({tag, "_count"}, 32'(count_o), 0);
        for (int k = 0; k < MD; k++) chk($sformatf("%s_data[%0d]", tag, k), 32'(data_o[k]), 0);
    endtask

    task automatic push(input logic [DW-1:0] w, input bit e);
        src_w.push_back(w);
        src_e.push_back(e);
    endtask

    function automatic int pick(input int mode, input int hi);
        return (mode < 0) ? int'($urandom_range(0, hi)) : mode;
    endfunction

    // Plays src_w/src_e into the DUT. gap_mode: idle cycles before each word
    // (-1 random 0..3); hold_mode: cycles rtr_i stays low once a frame is shown
    // (-1 random 0..5). Expected frames: words grouped until eow or MD words.
    task automatic run_stream(input int gap_mode, input int hold_mode);
        int            idx      = 0;
        int            n        = src_w.size();
        int            gap_left = pick(gap_mode, 3);
        int            hold     = pick(hold_mode, 5);
        int            full_cnt = 0;
        int            cycles   = 0;
        int            budget   = n * 12 + 200;
        logic [DW-1:0] cur [$];
        frame_t        f;
        bit            acc, take, last;
        while (idx < n || expq.size() != 0 || rts_o) begin
            if (cycles >= budget) begin
                chk("stream_budget_work_left", 32'(n - idx + expq.size() + int'(rts_o)), 0);
                break;
            end
            if (idx < n && gap_left == 0) begin
                rts_i  = 1'b1;
                data_i = src_w[idx];
                eow_i  = src_e[idx];
            end else begin
                rts_i  = 1'b0;
                data_i = DW'($urandom);
                eow_i  = 1'($urandom_range(0, 1));
                if (gap_left > 0) gap_left--;
            end
            if (rts_o) begin
                rtr_i = (full_cnt >= hold);
                full_cnt++;
            end else begin
                rtr_i = 1'($urandom_range(0, 1));
            end
            acc  = rts_i && rtr_o;
            take = rts_o && rtr_i;
            @(posedge clk);
            #1;
            cycles++;
            if (acc) begin
                cur.push_back(src_w[idx]);
                last = src_e[idx] || (cur.size() == MD);
                if (last) begin
                    for (int k = 0; k < MD; k++) f.w[k] = (k < cur.size()) ? cur[k] : '0;
                    f.len = cur.size();
                    f.eow = src_e[idx];
                    expq.push_back(f);
                    cur.delete();
                    chk("rts_after_last_word", 32'(rts_o), 1);
                    chk("rtr_low_after_last_word", 32'(rtr_o), 0);
                end else begin
                    chk("rts_low_mid_frame", 32'(rts_o), 0);
                    chk("rtr_high_mid_frame", 32'(rtr_o), 1);
                end
                idx++;
                gap_left = pick(gap_mode, 3);
            end
            if (take) begin
                void'(expq.pop_front());
                full_cnt = 0;
                hold     = pick(hold_mode, 5);
                chk("rts_low_after_take", 32'(rts_o), 0);
                chk("rtr_high_after_take", 32'(rtr_o), 1);
                chk("count_cleared_after_take", 32'(count_o), 0);
                chk("eow_cleared_after_take", 32'(eow_o), 0);
            end
            if (rts_o) begin
                if (expq.size() == 0) begin
                    chk("unexpected_frame_rts", 32'(rts_o), 0);
                end else begin
                    chk("frame_count", 32'(count_o), 32'(expq[0].len));
                    chk("frame_eow", 32'(eow_o), 32'(expq[0].eow));
                    chk("frame_rtr_low", 32'(rtr_o), 0);
                    for (int k = 0; k < MD; k++)
                        chk($sformatf("frame_data[%0d]", k), 32'(data_o[k]), 32'(expq[0].w[k]));
                end
            end else if (!acc && !take) begin
                chk("rtr_holds_in_fill", 32'(rtr_o), 1);
            end
        end
        chk("stream_partial_words_left", 32'(cur.size()), 0);
        rts_i = 1'b0;
        eow_i = 1'b0;
        rtr_i = 1'b0;
        src_w.delete();
        src_e.delete();
        expq.delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rtr_low_first_edge", 32'(rtr_o), 0);
        @(posedge clk);
        #1;
        chk("rtr_high_second_edge", 32'(rtr_o), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        rst    = 1'b1;
        rts_i  = 1'b0;
        eow_i  = 1'b0;
        data_i = '0;
        rtr_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        release_reset();

        // Full frame 1..20, downstream always ready.
        for (int i = 1; i <= 20; i++) push(DW'(i), 1'b0);
        run_stream(0, 0);

        // Downstream stalls 5 cycles; word 21 held at input lands in mem[0].
        for (int i = 1; i <= 25; i++) push(DW'(i), i == 25);
        run_stream(0, 5);

        // Nonzero full frame followed by a short frame: tail must read zero.
        for (int i = 0; i < 20; i++) push(DW'(16'h5500 + i), 1'b0);
        for (int i = 1; i <= 5; i++) push(DW'(16'h00A0 + i), i == 5);
        run_stream(0, -1);

        // eow on the 20th word with 3-cycle gaps between words.
        for (int i = 1; i <= 20; i++) push(DW'(16'h0300 + i), i == 20);
        run_stream(3, 1);

        // Reset in the middle of a fill, then a fresh frame 100..119.
        rtr_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rts_i  = 1'b1;
            data_i = DW'(50 + i);
            eow_i  = 1'b0;
            @(posedge clk);
            #1;
        end
        rts_i = 1'b0;
        chk("mid_fill_rts_low", 32'(rts_o), 0);
        chk("mid_fill_rtr_high", 32'(rtr_o), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        release_reset();
        for (int i = 100; i <= 119; i++) push(DW'(i), 1'b0);
        run_stream(0, 0);

        // 45 random words, eow on the last: frames of 20, 20, 5.
        for (int i = 1; i <= 45; i++) push(DW'($urandom), i == 45);
        run_stream(-1, -1);

        // Random streams with random eow positions.
        for (int s = 0; s < 4; s++) begin
            len = int'($urandom_range(1, 50));
            for (int i = 1; i <= len; i++)
                push(DW'($urandom), (i == len) || ($urandom_range(0, 7) == 0));
            run_stream(-1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
